// File: rtl/sha256_sched_pkg.sv
// Shared types for the SHA-256 job scheduler: FSM state encoding, queued job
// descriptor and a saturating increment helper for the run-length counter.
package sha256_sched_pkg;

  localparam int TAG_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    REPORT
  } state_t;

  typedef struct packed {
    logic [15:0]          input_addr;
    logic [15:0]          hash_addr;
    logic [TAG_W_DEF-1:0] tag;
  } job_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sha256_job_fifo.sv
// Synchronous job descriptor FIFO with occupancy level; DEPTH must be a power of two.
module sha256_job_fifo
  import sha256_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  job_t        wr_data,
  input  logic        pop,
  output job_t        rd_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);

  job_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/sha256_job_scheduler.sv
// Queues hash jobs and runs them one at a time on a single SHA-256 core.
// Define SHA_SCHED_PERF_EN to report each job's run length on cmpl_cycles.
module sha256_job_scheduler
  import sha256_sched_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int TAG_W         = TAG_W_DEF,
  parameter int START_TIMEOUT = 4,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [15:0]      job_input_addr,
  input  logic [15:0]      job_hash_addr,
  input  logic [TAG_W-1:0] job_tag,
  output logic             core_start,
  output logic [15:0]      core_input_addr,
  output logic [15:0]      core_hash_addr,
  input  logic             core_done,
  output logic             cmpl_valid,
  input  logic             cmpl_ready,
  output logic [TAG_W-1:0] cmpl_tag,
  output logic [15:0]      cmpl_cycles,
  output logic             busy,
  output logic [LW-1:0]    queue_level
);

  localparam logic [3:0] TMO_LAST = 4'(START_TIMEOUT - 1);

  state_t           state;
  job_t             push_job;
  job_t             head_job;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic [TAG_W-1:0] cur_tag;
  logic [3:0]       tmo_cnt;

  assign push_job  = '{input_addr: job_input_addr, hash_addr: job_hash_addr, tag: job_tag};
  assign pop       = (state == IDLE) && !fifo_empty && core_done;
  assign job_ready = !fifo_full;
  assign busy      = (state != IDLE);

  sha256_job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (job_valid),
    .wr_data (push_job),
    .pop     (pop),
    .rd_data (head_job),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (queue_level)
  );

  // A start the core never acknowledges (done stays high) is re-issued after
  // START_TIMEOUT cycles in WAIT_BUSY, without popping another job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      core_start      <= 1'b0;
      core_input_addr <= '0;
      core_hash_addr  <= '0;
      cur_tag         <= '0;
      tmo_cnt         <= '0;
      cmpl_valid      <= 1'b0;
      cmpl_tag        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state           <= LAUNCH;
            core_start      <= 1'b1;
            core_input_addr <= head_job.input_addr;
            core_hash_addr  <= head_job.hash_addr;
            cur_tag         <= head_job.tag;
          end
        end
        LAUNCH: begin
          core_start <= 1'b0;
          tmo_cnt    <= '0;
          state      <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!core_done) begin
            state <= WAIT_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            state      <= LAUNCH;
            core_start <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 4'd1;
          end
        end
        WAIT_DONE: begin
          if (core_done) begin
            state      <= REPORT;
            cmpl_valid <= 1'b1;
            cmpl_tag   <= cur_tag;
          end
        end
        REPORT: begin
          if (cmpl_ready) begin
            cmpl_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHA_SCHED_PERF_EN
  logic [15:0] perf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt    <= '0;
      cmpl_cycles <= '0;
    end else begin
      case (state)
        LAUNCH:    perf_cnt <= '0;
        WAIT_BUSY: perf_cnt <= sat_inc16(perf_cnt);
        WAIT_DONE: begin
          if (core_done) cmpl_cycles <= perf_cnt;
          else           perf_cnt    <= sat_inc16(perf_cnt);
        end
        default: ;
      endcase
    end
  end
`else
  assign cmpl_cycles = '0;
`endif

endmodule

// File: tb/tb_sha256_job_scheduler.sv
// Directed bench for sha256_job_scheduler: vector table of single jobs plus
// hand-written sequences for queueing, back-pressure, retry and reset.
module tb_sha256_job_scheduler;

`ifdef SHA_SCHED_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        job_valid;
  logic        job_ready;
  logic [15:0] job_input_addr;
  logic [15:0] job_hash_addr;
  logic [3:0]  job_tag;
  logic        core_start;
  logic [15:0] core_input_addr;
  logic [15:0] core_hash_addr;
  logic        done_m = 1'b1;
  logic        cmpl_valid;
  logic        cmpl_ready;
  logic [3:0]  cmpl_tag;
  logic [15:0] cmpl_cycles;
  logic        busy;
  logic [2:0]  queue_level;

  always #5 clk = ~clk;

  sha256_job_scheduler #(.DEPTH(4), .TAG_W(4), .START_TIMEOUT(TMO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_input_addr  (job_input_addr),
    .job_hash_addr   (job_hash_addr),
    .job_tag         (job_tag),
    .core_start      (core_start),
    .core_input_addr (core_input_addr),
    .core_hash_addr  (core_hash_addr),
    .core_done       (done_m),
    .cmpl_valid      (cmpl_valid),
    .cmpl_ready      (cmpl_ready),
    .cmpl_tag        (cmpl_tag),
    .cmpl_cycles     (cmpl_cycles),
    .busy            (busy),
    .queue_level     (queue_level)
  );

  // Core model, event recorders and address-hold monitor
  int          cyc = 0;
  int          cnt_m = 0;
  int          lat = 10;
  int          ign_req = 0;
  int          ign_cnt = 0;
  int          st_cyc[$];
  logic [15:0] st_ia[$];
  logic [15:0] st_ha[$];
  int          hs_cyc[$];
  int          hs_tag[$];
  int          hs_cv[$];
  int          addr_glitch = 0;
  logic        prev_busy = 1'b0;
  logic [15:0] prev_ia = '0;
  logic [15:0] prev_ha = '0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (core_start) begin
      st_cyc.push_back(cyc);
      st_ia.push_back(core_input_addr);
      st_ha.push_back(core_hash_addr);
    end
    if (cmpl_valid && cmpl_ready) begin
      hs_cyc.push_back(cyc);
      hs_tag.push_back(int'(cmpl_tag));
      hs_cv.push_back(int'(cmpl_cycles));
    end
    if (prev_busy && busy && (core_input_addr != prev_ia || core_hash_addr != prev_ha))
      addr_glitch = addr_glitch + 1;
    prev_busy = busy;
    prev_ia   = core_input_addr;
    prev_ha   = core_hash_addr;
    if (core_start && ign_cnt < ign_req) begin
      ign_cnt = ign_cnt + 1;
    end else if (core_start) begin
      done_m <= 1'b0;
      cnt_m  <= lat - 1;
    end else if (!done_m) begin
      if (cnt_m == 0) done_m <= 1'b1;
      else            cnt_m  <= cnt_m - 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string p);
    chk({p, "_job_ready"}, job_ready, 1);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_level"}, queue_level, 0);
    chk({p, "_core_start"}, core_start, 0);
    chk({p, "_core_ia"}, core_input_addr, 0);
    chk({p, "_core_ha"}, core_hash_addr, 0);
    chk({p, "_cmpl_valid"}, cmpl_valid, 0);
    chk({p, "_cmpl_tag"}, cmpl_tag, 0);
    chk({p, "_cmpl_cycles"}, cmpl_cycles, 0);
  endtask

  task automatic push_one(input logic [15:0] ia, input logic [15:0] ha,
                          input logic [3:0] tag, output int pedge);
    @(negedge clk);
    job_input_addr = ia;
    job_hash_addr  = ha;
    job_tag        = tag;
    job_valid      = 1'b1;
    pedge          = cyc + 1;
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_cmpl(input int target, input string name);
    int k = 0;
    while (hs_tag.size() < target && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk(name, hs_tag.size(), target);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!cmpl_valid && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk(name, cmpl_valid, 1);
  endtask

  typedef struct {
    logic [15:0] ia;
    logic [15:0] ha;
    logic [3:0]  tag;
    int          lat;
    int          exp_delay;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int p, sb, hb, k, bad, h;

    vecs[0] = '{16'h0000, 16'h0100, 4'd3,  100, 2, PERF ? 100 : 0};
    vecs[1] = '{16'h1234, 16'hABCD, 4'd7,  10,  2, PERF ? 10 : 0};
    vecs[2] = '{16'hFFFF, 16'h0000, 4'd15, 1,   2, PERF ? 1 : 0};
    vecs[3] = '{16'h0042, 16'h8000, 4'd0,  5,   2, PERF ? 5 : 0};

    rst_n = 1'b0;
    job_valid = 1'b0;
    job_input_addr = '0;
    job_hash_addr = '0;
    job_tag = '0;
    cmpl_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      sb  = st_cyc.size();
      hb  = hs_tag.size();
      lat = vecs[i].lat;
      push_one(vecs[i].ia, vecs[i].ha, vecs[i].tag, p);
      wait_cmpl(hb + 1, "vec_done");
      repeat (3) @(negedge clk);
      chk("vec_start_count", st_cyc.size() - sb, 1);
      chk("vec_start_delay", st_cyc[sb] - p, vecs[i].exp_delay);
      chk("vec_core_ia", st_ia[sb], vecs[i].ia);
      chk("vec_core_ha", st_ha[sb], vecs[i].ha);
      chk("vec_cmpl_tag", hs_tag[hb], vecs[i].tag);
      chk("vec_cmpl_cycles", hs_cv[hb], vecs[i].exp_cycles);
      chk("vec_idle", busy, 0);
    end

    // Five jobs into a 4-deep queue while job 1 runs
    sb = st_cyc.size();
    hb = hs_tag.size();
    lat = 20;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      job_input_addr = 16'h1000 + 16'(i);
      job_hash_addr  = 16'h2000 + 16'(i);
      job_tag        = 4'(i);
      job_valid      = 1'b1;
    end
    @(negedge clk);
    chk("full_job_ready", job_ready, 0);
    chk("full_level", queue_level, 4);
    job_tag = 4'd9;
    repeat (3) @(negedge clk);
    job_valid = 1'b0;
    chk("full_ignore_level", queue_level, 4);
    wait_cmpl(hb + 5, "five_done");
    repeat (5) @(negedge clk);
    chk("five_start_count", st_cyc.size() - sb, 5);
    for (int i = 0; i < 5; i++) begin
      chk("five_tag_order", hs_tag[hb + i], i + 1);
      chk("five_core_ia", st_ia[sb + i], 16'h1001 + i);
    end
    for (int i = 0; i < 4; i++)
      chk("five_hs_to_start", st_cyc[sb + i + 1] - hs_cyc[hb + i], 2);

    // Completion back-pressure
    cmpl_ready = 1'b0;
    lat = 5;
    hb = hs_tag.size();
    push_one(16'h3000, 16'h3100, 4'd6, p);
    wait_valid("bp_valid");
    sb = st_cyc.size();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!cmpl_valid || cmpl_tag != 4'd6) bad++;
      if (c == 2) begin
        job_input_addr = 16'h3A00; job_hash_addr = 16'h3B00; job_tag = 4'd10; job_valid = 1'b1;
      end else if (c == 3) begin
        job_input_addr = 16'h3C00; job_hash_addr = 16'h3D00; job_tag = 4'd11;
      end else if (c == 4) begin
        job_valid = 1'b0;
      end
    end
    chk("bp_stable", bad, 0);
    chk("bp_no_start", st_cyc.size() - sb, 0);
    chk("bp_level", queue_level, 2);
    cmpl_ready = 1'b1;
    wait_cmpl(hb + 3, "bp_done");
    chk("bp_tag0", hs_tag[hb], 6);
    chk("bp_tag1", hs_tag[hb + 1], 10);
    chk("bp_tag2", hs_tag[hb + 2], 11);

    // Ignored first start -> re-issue after the timeout
    repeat (3) @(negedge clk);
    lat = 6;
    ign_req = ign_cnt + 1;
    sb = st_cyc.size();
    hb = hs_tag.size();
    push_one(16'h4444, 16'h5555, 4'd12, p);
    wait_cmpl(hb + 1, "retry_done");
    repeat (10) @(negedge clk);
    chk("retry_start_count", st_cyc.size() - sb, 2);
    chk("retry_gap", st_cyc[sb + 1] - st_cyc[sb], TMO + 1);
    chk("retry_ia", st_ia[sb + 1], 16'h4444);
    chk("retry_ha", st_ha[sb + 1], 16'h5555);
    chk("retry_one_cmpl", hs_tag.size() - hb, 1);
    chk("retry_tag", hs_tag[hb], 12);
    chk("retry_cycles", hs_cv[hb], PERF ? 6 : 0);

    // Reset while a job is in WAIT_DONE with two more queued
    lat = 30;
    push_one(16'h0A00, 16'h0B00, 4'd1, p);
    push_one(16'h0A10, 16'h0B10, 4'd2, p);
    push_one(16'h0A20, 16'h0B20, 4'd3, p);
    k = 0;
    while (done_m && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_level", queue_level, 2);
    rst_n = 1'b0;
    #1;
    check_reset("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    sb = st_cyc.size();
    hb = hs_tag.size();
    repeat (50) @(negedge clk);
    chk("post_rst_no_cmpl", hs_tag.size() - hb, 0);
    chk("post_rst_no_start", st_cyc.size() - sb, 0);
    chk("post_rst_level", queue_level, 0);
    chk("post_rst_job_ready", job_ready, 1);

    // Push into an empty queue in the handshake cycle
    cmpl_ready = 1'b0;
    lat = 4;
    hb = hs_tag.size();
    push_one(16'h6000, 16'h6100, 4'd13, p);
    wait_valid("hsp_valid");
    cmpl_ready = 1'b1;
    job_input_addr = 16'h7000;
    job_hash_addr  = 16'h7100;
    job_tag        = 4'd14;
    job_valid      = 1'b1;
    sb = st_cyc.size();
    h = cyc + 1;
    @(negedge clk);
    job_valid = 1'b0;
    wait_cmpl(hb + 2, "hsp_done");
    chk("hsp_hs_edge", hs_cyc[hb], h);
    chk("hsp_start_delay", st_cyc[sb] - h, 2);
    chk("hsp_core_ia", st_ia[sb], 16'h7000);
    chk("hsp_core_ha", st_ha[sb], 16'h7100);
    chk("hsp_tag", hs_tag[hb + 1], 14);

    chk("addr_hold", addr_glitch, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
